// File: rtl/stop_status_pkg.sv
// Shared types for the multi-channel stop status bank.
// Optional build macro: STOP_STATUS_GET_EDGE_EN (see stop_status_ch).
package stop_status_pkg;

  localparam int unsigned MODE_W = 2;

  // Per-channel stop-status behaviour; the reserved code falls back to toggle.
  typedef enum logic [MODE_W-1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_LATCH   = 2'b01,
    MODE_STRETCH = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

endpackage : stop_status_pkg

// File: rtl/stop_status_ch.sv
// One stop-status channel: strobe holdoff, mode-dependent q, saturating count.
// Macro STOP_STATUS_GET_EDGE_EN: get passes through a registered rising-edge
// detector (one extra cycle of latency); otherwise get is level-sensitive.
module stop_status_ch
  import stop_status_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              live_rising_i,
  input  logic              get_i,
  input  logic [1:0]        mode_i,
  input  logic [HOLD_W-1:0] holdoff_i,
  output logic              q_o,
  output logic              q_next_o,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [HOLD_W-1:0] HC_ZERO = '0;

  mode_e mode;
  logic  ev;

  logic              q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hc_q, hc_d;

  logic              q_base;
  logic [CNT_W-1:0]  cnt_base;
  logic [HOLD_W-1:0] hc_base;
  logic              accept;

  assign mode = mode_e'(mode_i);

`ifdef STOP_STATUS_GET_EDGE_EN
  logic get_q, get_prev_q;

  // Registered edge detector; reset to 0 so a get high at release is an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      get_q      <= 1'b0;
      get_prev_q <= 1'b0;
    end else begin
      get_q      <= get_i;
      get_prev_q <= get_q;
    end
  end

  assign ev = get_q & ~get_prev_q;
`else
  assign ev = get_i;
`endif

  // Next state: live_rising clears first, then the strobe is judged on the cleared state.
  always_comb begin
    q_base   = live_rising_i ? 1'b0 : q_q;
    cnt_base = live_rising_i ? '0   : cnt_q;
    hc_base  = live_rising_i ? '0   : hc_q;
    accept   = ev && (hc_base == HC_ZERO);
    q_d      = q_base;
    cnt_d    = cnt_base;
    hc_d     = hc_base;

    if (accept) begin
      hc_d = holdoff_i;
      if (cnt_base != CNT_MAX) begin
        cnt_d = cnt_base + CNT_W'(1);
      end
      case (mode)
        MODE_LATCH, MODE_STRETCH: q_d = 1'b1;
        default:                  q_d = ~q_base;
      endcase
    end else begin
      // Stretch pulse ends once the holdoff window has fully drained.
      if ((mode == MODE_STRETCH) && (hc_base == HC_ZERO)) begin
        q_d = 1'b0;
      end
      if (hc_base != HC_ZERO) begin
        hc_d = hc_base - HOLD_W'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= 1'b0;
      cnt_q <= '0;
      hc_q  <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      hc_q  <= hc_d;
    end
  end

  assign q_o      = q_q;
  assign q_next_o = q_d;
  assign cnt_o    = cnt_q;

endmodule : stop_status_ch

// File: rtl/stop_status_bank.sv
// Multi-channel stop status bank beside the live/run controller.
// live_rising snapshots all q bits into q_snap and clears every channel.
// Macro STOP_STATUS_GET_EDGE_EN selects edge-detected get inside each channel.
module stop_status_bank
  import stop_status_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned HOLD_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  live_rising,
  input  logic [N_CH-1:0]       get,
  input  logic [2*N_CH-1:0]     cfg_mode,
  input  logic [HOLD_W-1:0]     holdoff,
  output logic [N_CH-1:0]       q,
  output logic                  q_any,
  output logic [N_CH-1:0]       q_snap,
  output logic [N_CH*CNT_W-1:0] cnt
);

  logic [N_CH-1:0] q_w;
  logic [N_CH-1:0] q_next_w;
  logic [N_CH-1:0] q_snap_q, q_snap_d;
  logic            q_any_q, q_any_d;

  // Independent channels, packed onto the flat output buses.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    stop_status_ch #(
      .CNT_W  (CNT_W),
      .HOLD_W (HOLD_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .live_rising_i (live_rising),
      .get_i         (get[i]),
      .mode_i        (cfg_mode[2*i +: 2]),
      .holdoff_i     (holdoff),
      .q_o           (q_w[i]),
      .q_next_o      (q_next_w[i]),
      .cnt_o         (cnt[CNT_W*i +: CNT_W])
    );
  end

  // Snapshot of pre-clear q and OR of next-state q so q_any lines up with q.
  always_comb begin
    q_snap_d = q_snap_q;
    q_any_d  = |q_next_w;
    if (live_rising) begin
      q_snap_d = q_w;
    end
  end

  // Bank-level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_snap_q <= '0;
      q_any_q  <= 1'b0;
    end else begin
      q_snap_q <= q_snap_d;
      q_any_q  <= q_any_d;
    end
  end

  assign q      = q_w;
  assign q_any  = q_any_q;
  assign q_snap = q_snap_q;

endmodule : stop_status_bank

// File: doc/stop_status_bank.md
Name: stop_status_bank

Overview:
- Parametrised, multi-channel successor to the single-bit stop status flag.
- Each channel tracks a stop condition from a `get` strobe, in one of three runtime-selectable modes.
- Each channel also has a programmable holdoff that rejects repeated strobes, and a saturating count of accepted events per live period.
- Sits beside the live/run controller; `live_rising` opens a new live period, snapshots all flags, then clears them.

Parameters:
- N_CH, 4: number of independent channels (1..32).
- CNT_W, 8: width of each per-channel accepted-event counter.
- HOLD_W, 4: width of the holdoff counter; holdoff length comes from the `holdoff` port.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- live_rising  in  1  single-cycle start-of-live-period strobe.
- get  in  N_CH  per-channel stop strobe.
- cfg_mode  in  2*N_CH  per-channel mode; channel i uses bits [2i+1:2i].
- holdoff  in  HOLD_W  cycles during which a channel ignores `get` after an accepted one (0 = no holdoff).
- q  out  N_CH  per-channel stop status.
- q_any  out  1  registered OR of all q bits.
- q_snap  out  N_CH  q as it stood in the cycle live_rising was sampled.
- cnt  out  N_CH*CNT_W  per-channel accepted-event count; channel i uses [CNT_W*(i+1)-1:CNT_W*i].

Behaviour:
- Reset: q, q_any, q_snap, cnt and all holdoff counters are 0. Release needs no synchronisation here.
- Accept rule: get[i] is accepted in a cycle when get[i] = 1 and holdoff counter hc[i] = 0.
  - An accepted get loads hc[i] with `holdoff`.
  - Otherwise hc[i] decrements while non-zero.
  - A get seen while hc[i] != 0 is dropped silently and does not reload hc.
- Modes (cfg_mode per channel, sampled each cycle):
  - 00 TOGGLE: an accepted get inverts q[i].
  - 01 LATCH: an accepted get sets q[i] = 1; q[i] stays 1 until live_rising.
  - 10 STRETCH: an accepted get sets q[i] = 1. q[i] returns to 0 when hc[i] reaches 0; with holdoff = 0, q[i] is high for exactly 1 cycle.
  - 11: reserved; behaves as TOGGLE.
- Latency: q, cnt and q_any update on the clock edge at which get is sampled. q_any is the OR of the next-state q, so it is coincident with q and has no extra cycle of lag.
- Counter: cnt[i] increments by 1 on each accepted get and saturates at 2^CNT_W - 1. No wrap.
- live_rising, all channels, same edge:
  - q_snap <= current q.
  - q <= 0, cnt <= 0, hc <= 0.
- live_rising and get[i] in the same cycle: the clear is applied first, then get[i] is evaluated as accepted, since hc is cleared.
  - Result: q[i] = 1 in every mode, cnt[i] = 1, hc[i] = holdoff.
  - q_snap still captures the pre-clear q.
- Mode change mid-operation: takes effect next cycle; q, cnt and hc are not disturbed.
  - A channel leaving STRETCH with q = 1 holds q until its next event in the new mode.
- holdoff change mid-count: affects only future loads.
- Asynchronous rst at any time overrides everything.

Optional Feature:
- Macro: STOP_STATUS_GET_EDGE_EN.
- Defined:
  - each get[i] passes through a registered rising-edge detector, so only a 0->1 transition counts as a strobe;
  - a get held high yields one event;
  - adds 1 cycle of latency from get to q/cnt;
  - the edge register resets to 0, so a get already high when rst releases counts as an edge.
- Undefined: get is level-sensitive; every high cycle is a candidate event, as in the legacy flag.

Decomposition:
- Package stop_status_pkg:
  - 2-bit mode constants MODE_TOGGLE = 2'b00, MODE_LATCH = 2'b01, MODE_STRETCH = 2'b10;
  - a mode typedef.
- Sub-module stop_status_ch:
  - one channel with q, hc, cnt and the optional edge detector;
  - instantiated N_CH times by a generate loop.
- The top holds the q_snap register, the q_any reduction, and the bus packing.

Test Plan:
1. Reset and toggle: rst pulse; check q = 0, cnt = 0. Then channel 0 in TOGGLE, holdoff = 0, get[0] high for 3 consecutive cycles -> q[0] sequence 1,0,1 and cnt[0] = 3.
2. Holdoff: holdoff = 3, get[1] high for 6 cycles in TOGGLE -> accepted on cycles 1 and 5 only; q[1] ends at 0, cnt[1] = 2.
3. LATCH and STRETCH: channel 2 in LATCH with gets at t = 2 and t = 7 -> q[2] stays 1. Channel 3 in STRETCH with holdoff = 2 and one get -> q[3] high for exactly 3 cycles.
4. Snapshot and simultaneous: q = 4'b0101, then live_rising together with get[2] -> q_snap = 4'b0101, q = 4'b0100, cnt[2] = 1, other cnt = 0.
5. Saturation: CNT_W = 3, 10 accepted gets on channel 0 -> cnt[0] = 7; q_any follows q each cycle.
6. Async reset mid-holdoff: assert rst between clock edges while hc = 2 and q = 1 -> all outputs 0 immediately; the first get after release is accepted.
